// File: rtl/hazard_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and limits for the hazard stall controller.
// Rev     : 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    typedef logic [3:0] cnt_t;

    localparam int c_LOAD_LATENCY_MIN = 1;
    localparam int c_LOAD_LATENCY_MAX = 15;

    // Out-of-range latencies are clamped so the 4-bit counter never wraps.
    function automatic cnt_t load_cnt_init(input int ll);
        int v;
        v = ll;
        if (v < c_LOAD_LATENCY_MIN) v = c_LOAD_LATENCY_MIN;
        if (v > c_LOAD_LATENCY_MAX) v = c_LOAD_LATENCY_MAX;
        return cnt_t'(v - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_controller_if
// Brief   : Hazard events in, pipeline enables/bubbles and statistics out.
// Rev     : 1.0
// ============================================================================
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             stall_req;
    logic             branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_write;
    logic             stall_active;
    logic [CNT_W-1:0] stat_stall_cnt;
    logic [CNT_W-1:0] stat_flush_cnt;
    logic [CNT_W-1:0] stat_wait_cnt;

    modport master (
        output stall_req, branch_taken, dmem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        input  stall_active, stat_stall_cnt, stat_flush_cnt, stat_wait_cnt
    );

    modport slave (
        input  stall_req, branch_taken, dmem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
        output stall_active, stat_stall_cnt, stat_flush_cnt, stat_wait_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : W-bit up counter that sticks at all-ones; synchronous clear.
// Rev     : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         inc,
    output      logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_controller
// Brief   : Sequences pipeline enables/bubbles for load-use stalls, branch
//           flushes and data-memory waits. Define HAZARD_STATS_EN to build
//           the saturating statistics counters.
// Rev     : 1.0
// ============================================================================
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input wire logic              clk,
    input wire logic              rst_n,
    hazard_stall_controller_if.slave bus
);
    localparam cnt_t c_CNT_INIT = load_cnt_init(LOAD_LATENCY);
    localparam bit   c_MULTI    = (LOAD_LATENCY > 1);

    state_t r_state, r_ret_state;
    cnt_t   r_cnt;

    state_t w_eff_state, w_next_state, w_next_ret;
    cnt_t   w_next_cnt;
    logic   w_pc_write, w_ifid_write, w_ifid_flush;
    logic   w_idex_bubble, w_exmem_write, w_stall_active;

    // A falling dmem_busy resumes the saved context in the same cycle.
    assign w_eff_state = ((r_state == MEM_WAIT) && !bus.dmem_busy) ? r_ret_state : r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_cnt       <= w_next_cnt;
        end
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_write = 1'b1;
        w_next_state  = r_state;
        w_next_ret    = r_ret_state;
        w_next_cnt    = r_cnt;

        if (bus.dmem_busy) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_next_state  = MEM_WAIT;
            // Staying in MEM_WAIT keeps the context saved on entry.
            w_next_ret    = (r_state == MEM_WAIT) ? r_ret_state : r_state;
        end else if (bus.branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_next_state  = RUN;
            w_next_ret    = RUN;
            w_next_cnt    = '0;
        end else begin
            w_next_ret = RUN;
            case (w_eff_state)
                LOAD_STALL: begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    if (r_cnt == cnt_t'(1)) begin
                        w_next_state = RUN;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = LOAD_STALL;
                        w_next_cnt   = r_cnt - cnt_t'(1);
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                    if (bus.stall_req) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        if (c_MULTI) begin
                            w_next_state = LOAD_STALL;
                            w_next_cnt   = c_CNT_INIT;
                        end
                    end
                end
            endcase
        end

        w_stall_active = (r_state != RUN);

        if (!rst_n) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_bubble  = 1'b1;
            w_exmem_write  = 1'b0;
            w_stall_active = 1'b0;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.ifid_write   = w_ifid_write;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_bubble  = w_idex_bubble;
    assign bus.exmem_write  = w_exmem_write;
    assign bus.stall_active = w_stall_active;

`ifdef HAZARD_STATS_EN
    logic w_stall_inc, w_flush_inc, w_wait_inc;

    assign w_wait_inc  = rst_n & bus.dmem_busy;
    assign w_flush_inc = rst_n & ~bus.dmem_busy & bus.branch_taken;
    assign w_stall_inc = rst_n & ~bus.dmem_busy & ~bus.branch_taken &
                         (((w_eff_state == RUN) & bus.stall_req) | (w_eff_state == LOAD_STALL));

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .q     (bus.stat_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .q     (bus.stat_flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wait_inc),
        .q     (bus.stat_wait_cnt)
    );
`else
    assign bus.stat_stall_cnt = '0;
    assign bus.stat_flush_cnt = '0;
    assign bus.stat_wait_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_stall_controller
// Brief   : Bench for two controllers (LOAD_LATENCY 1 / CNT_W 16 and
//           LOAD_LATENCY 3 / CNT_W 4) against a remaining-bubble model.
// Rev     : 1.0
// ============================================================================
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_controller_if #(.CNT_W(16)) bus0 ();
    hazard_stall_controller_if #(.CNT_W(4))  bus1 ();

    hazard_stall_controller #(.LOAD_LATENCY(1), .CNT_W(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    hazard_stall_controller #(.LOAD_LATENCY(3), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, stall_active}
    wire [5:0] w_o0 = {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush,
                       bus0.idex_bubble, bus0.exmem_write, bus0.stall_active};
    wire [5:0] w_o1 = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush,
                       bus1.idex_bubble, bus1.exmem_write, bus1.stall_active};

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model: bubbles still owed after this cycle, and whether memory was waiting.
    int       m_rem  [2];
    bit       m_wait [2];
    int       m_st   [2][3];
    int       n_rem  [2];
    bit       n_wait [2];
    int       n_st   [2][3];
    logic [5:0] e_o  [2];
    int       e_st   [2][3];
    bit       pend = 1'b0;

    function automatic logic [5:0] outv(input int k);
        return (k == 0) ? w_o0 : w_o1;
    endfunction

    function automatic int statv(input int k, input int s);
        if (k == 0) begin
            case (s)
                0:       return int'(bus0.stat_stall_cnt);
                1:       return int'(bus0.stat_flush_cnt);
                default: return int'(bus0.stat_wait_cnt);
            endcase
        end
        case (s)
            0:       return int'(bus1.stat_stall_cnt);
            1:       return int'(bus1.stat_flush_cnt);
            default: return int'(bus1.stat_wait_cnt);
        endcase
    endfunction

    function automatic int latency(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int stat_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic apply(input bit r, input bit b, input bit br, input bit sr);
        bit act;
        @(negedge clk);
        if (pend) begin
            for (int k = 0; k < 2; k++) begin
                m_rem[k]  = n_rem[k];
                m_wait[k] = n_wait[k];
                for (int s = 0; s < 3; s++) m_st[k][s] = n_st[k][s];
            end
        end
        rst_n = r;
        bus0.dmem_busy = b; bus0.branch_taken = br; bus0.stall_req = sr;
        bus1.dmem_busy = b; bus1.branch_taken = br; bus1.stall_req = sr;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) begin
`ifdef HAZARD_STATS_EN
                e_st[k][s] = m_st[k][s];
`else
                e_st[k][s] = 0;
`endif
                n_st[k][s] = m_st[k][s];
            end
            act = (m_rem[k] > 0) || m_wait[k];
            if (!r) begin
                e_o[k]    = 6'b001100;
                n_rem[k]  = 0;
                n_wait[k] = 1'b0;
                for (int s = 0; s < 3; s++) n_st[k][s] = 0;
            end else if (b) begin
                e_o[k]    = {5'b00000, act};
                n_rem[k]  = m_rem[k];
                n_wait[k] = 1'b1;
                if (m_st[k][2] < stat_max(k)) n_st[k][2] = m_st[k][2] + 1;
            end else begin
                n_wait[k] = 1'b0;
                if (br) begin
                    e_o[k]   = {5'b11111, act};
                    n_rem[k] = 0;
                    if (m_st[k][1] < stat_max(k)) n_st[k][1] = m_st[k][1] + 1;
                end else if (m_rem[k] > 0 || sr) begin
                    e_o[k]   = {5'b00011, act};
                    n_rem[k] = (m_rem[k] > 0) ? m_rem[k] - 1 : latency(k) - 1;
                    if (m_st[k][0] < stat_max(k)) n_st[k][0] = m_st[k][0] + 1;
                end else begin
                    e_o[k]   = {5'b11001, act};
                    n_rem[k] = 0;
                end
            end
        end
        pend = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                chk_cnt++;
                if (outv(k) !== 6'b001100)
                    $display("FAIL reset_forced dut%0d: got %b expected %b", k, outv(k), 6'b001100);
                else pass_cnt++;
            end
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk_cnt++;
            if (outv(k) !== 6'b110010)
                $display("FAIL reset_release dut%0d: got %b expected %b", k, outv(k), 6'b110010);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_lat1();
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        chk_cnt++;
        if (w_o0 !== 6'b000110)
            $display("FAIL lat1_stall: got %b expected %b", w_o0, 6'b000110);
        else pass_cnt++;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (w_o0 !== 6'b110010)
            $display("FAIL lat1_resume: got %b expected %b", w_o0, 6'b110010);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_lat3();
        int bubbles = 0;
        int active  = 0;
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, 1'b0, 1'b0, (c == 0));
            bubbles += int'(bus1.idex_bubble);
            active  += int'(bus1.stall_active);
            for (int k = 0; k < 2; k++) begin
                chk_cnt++;
                if (outv(k) !== e_o[k])
                    $display("FAIL lat3_cycle%0d dut%0d: got %b expected %b", c, k, outv(k), e_o[k]);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (bubbles !== 3) $display("FAIL lat3_bubbles: got %0d expected 3", bubbles);
        else pass_cnt++;
        chk_cnt++;
        if (active !== 2) $display("FAIL lat3_active: got %0d expected 2", active);
        else pass_cnt++;
    endtask

    task automatic test_branch_priority();
        apply(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk_cnt++;
            if (outv(k) !== 6'b111110)
                $display("FAIL branch_prio dut%0d: got %b expected %b", k, outv(k), 6'b111110);
            else pass_cnt++;
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (w_o1 !== 6'b110010)
            $display("FAIL branch_no_stall: got %b expected %b", w_o1, 6'b110010);
        else pass_cnt++;
    endtask

    task automatic test_branch_abort();
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        chk_cnt++;
        if (w_o1 !== 6'b111111)
            $display("FAIL branch_abort: got %b expected %b", w_o1, 6'b111111);
        else pass_cnt++;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (w_o1 !== 6'b110010)
            $display("FAIL branch_abort_run: got %b expected %b", w_o1, 6'b110010);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        int bubbles = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1);
            chk_cnt++;
            if (w_o1 !== 6'b000001)
                $display("FAIL mem_wait_freeze%0d: got %b expected %b", c, w_o1, 6'b000001);
            else pass_cnt++;
        end
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0);
            if (c == 0) begin
                chk_cnt++;
                if (w_o1 !== 6'b000111)
                    $display("FAIL mem_wait_release: got %b expected %b", w_o1, 6'b000111);
                else pass_cnt++;
            end
            bubbles += int'(bus1.idex_bubble);
        end
        chk_cnt++;
        if (bubbles !== 2) $display("FAIL mem_wait_bubbles: got %0d expected 2", bubbles);
        else pass_cnt++;
    endtask

    task automatic test_stats();
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) apply(1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        chk_cnt++;
        if (int'(bus1.stat_wait_cnt) !== 15)
            $display("FAIL stats_wait_sat: got %0d expected 15", bus1.stat_wait_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (int'(bus0.stat_wait_cnt) !== 20)
            $display("FAIL stats_wait_wide: got %0d expected 20", bus0.stat_wait_cnt);
        else pass_cnt++;
`else
        chk_cnt++;
        if ({bus0.stat_stall_cnt, bus0.stat_flush_cnt, bus0.stat_wait_cnt,
             bus1.stat_stall_cnt, bus1.stat_flush_cnt, bus1.stat_wait_cnt} !== 60'd0)
            $display("FAIL stats_tied: got %0d/%0d expected 0", bus0.stat_wait_cnt, bus1.stat_wait_cnt);
        else pass_cnt++;
`endif
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) begin
                chk_cnt++;
                if (statv(k, s) !== e_st[k][s])
                    $display("FAIL stats_model dut%0d ctr%0d: got %0d expected %0d", k, s, statv(k, s), e_st[k][s]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
            for (int k = 0; k < 2; k++) begin
                chk_cnt++;
                if (outv(k) !== e_o[k])
                    $display("FAIL random_out c%0d dut%0d: got %b expected %b", c, k, outv(k), e_o[k]);
                else pass_cnt++;
                for (int s = 0; s < 3; s++) begin
                    chk_cnt++;
                    if (statv(k, s) !== e_st[k][s])
                        $display("FAIL random_stat c%0d dut%0d ctr%0d: got %0d expected %0d",
                                 c, k, s, statv(k, s), e_st[k][s]);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.stall_req = 1'b0; bus0.branch_taken = 1'b0; bus0.dmem_busy = 1'b0;
        bus1.stall_req = 1'b0; bus1.branch_taken = 1'b0; bus1.dmem_busy = 1'b0;
        test_reset();
        test_load_lat1();
        test_load_lat3();
        test_branch_priority();
        test_branch_abort();
        test_mem_wait();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Consumer side of the load-use hazard signal. Takes the combinational stall request plus branch-flush and data-memory-wait events and sequences the pipeline write enables and bubble controls for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM). Holds multi-cycle load stalls and memory waits in a small FSM, so the upstream detector stays purely combinational.

Parameters:
- LOAD_LATENCY, 1, number of ID/EX bubbles per load-use stall (1..15).
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- stall_req  in  1  load-use hazard from the detector (ID/EX load targets an IF/ID source).
- branch_taken  in  1  redirect resolved; squash the instructions in IF/ID and ID.
- dmem_busy  in  1  data memory not ready; freeze the whole pipeline.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP (has priority over ifid_write in the register).
- idex_bubble  out  1  load NOP control into ID/EX.
- exmem_write  out  1  EX/MEM and MEM/WB load enable.
- stall_active  out  1  high in LOAD_STALL or MEM_WAIT.
- stat_stall_cnt, stat_flush_cnt, stat_wait_cnt  out  CNT_W  statistics (see Optional Feature).

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. Registers: state, ret_state (RUN/LOAD_STALL), cnt (4 bits).
- Reset: on a clk edge with rst_n=0, state=RUN, ret_state=RUN, cnt=0.
  - While rst_n=0, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_write=0, stall_active=0.
  - Reset mid-stall or mid-wait aborts it; there is no resume.
- Outputs are combinational from eff_state and the inputs; zero latency.
  - eff_state = ret_state when state=MEM_WAIT and dmem_busy=0; otherwise eff_state = state.
- Event priority in every state: dmem_busy > branch_taken > stall_req.
- Default outputs are all enables 1, ifid_flush=0, idex_bubble=0.
- dmem_busy=1 in any state:
  - pc_write=0, ifid_write=0, exmem_write=0, idex_bubble=0, ifid_flush=0.
  - Next state is MEM_WAIT. ret_state captures the current eff_state. cnt is frozen.
  - branch_taken and stall_req are ignored while dmem_busy=1.
- eff_state RUN:
  - branch_taken=1: pc_write=1, ifid_flush=1, idex_bubble=1. stall_req is ignored. Stay in RUN.
  - Otherwise stall_req=1: pc_write=0, ifid_write=0, idex_bubble=1.
    - LOAD_LATENCY=1: stay in RUN.
    - LOAD_LATENCY>1: go to LOAD_STALL with cnt=LOAD_LATENCY-1.
- eff_state LOAD_STALL:
  - pc_write=0, ifid_write=0, idex_bubble=1. stall_req is don't-care.
  - cnt decrements each cycle. When cnt==1 at the edge, go to RUN with cnt=0.
  - Total bubbles per stall = LOAD_LATENCY exactly.
  - branch_taken=1: abort the stall. Outputs as RUN+branch; next state RUN, cnt=0.
- MEM_WAIT with dmem_busy falling: the controller acts as ret_state in that same cycle, with no extra dead cycle. Next state follows ret_state's transition rules.
- stall_active = (state != RUN), registered-state based.

Optional Feature:
HAZARD_STATS_EN
- Defined: three saturating CNT_W-bit counters, cleared by reset. They stick at all-ones.
  - stat_stall_cnt increments each cycle idex_bubble=1 due to stall_req or LOAD_STALL.
  - stat_flush_cnt increments each cycle branch_taken takes effect.
  - stat_wait_cnt increments each cycle dmem_busy=1.
- Undefined: stat_* ports are present and tied to 0; no counter flops are generated.

Decomposition:
- Package hazard_pkg: state enum typedef {RUN, LOAD_STALL, MEM_WAIT}, the 4-bit cnt typedef, LOAD_LATENCY range limits.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output q). It is instantiated three times under HAZARD_STATS_EN.

Test Plan:
- Reset: rst_n=0 for 2 cycles with stall_req=1 -> outputs at forced reset values; after release, pc_write=ifid_write=exmem_write=1 and state=RUN.
- LOAD_LATENCY=1: stall_req pulse for 1 cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle all enables 1.
- LOAD_LATENCY=3: stall_req for 1 cycle -> idex_bubble=1 for exactly 3 cycles and stall_active=1 for 2 cycles, then RUN.
- Branch priority: stall_req=1 and branch_taken=1 together -> pc_write=1, ifid_flush=1, idex_bubble=1, no LOAD_STALL entry.
  - Branch_taken on the 2nd cycle of a 3-cycle LOAD_STALL -> immediate RUN.
- Memory wait: dmem_busy high for 4 cycles during LOAD_STALL with cnt=2 -> all enables 0 for 4 cycles and cnt unchanged.
  - On the release cycle, idex_bubble=1 (resumed stall); remaining bubbles total 2.
- HAZARD_STATS_EN with CNT_W=4: 20 dmem_busy cycles -> stat_wait_cnt saturates at 15.
  - Same stimulus without the macro -> all stat_* = 0.
